// File: rtl/dds_wave_gen.sv
// dds_wave_gen: DDS waveform generator with a phase accumulator, a shadow configuration
// that is applied at phase wrap, four waveforms and an optional amplitude scaler.
// Optional feature macro: DDS_AMP_SCALE_EN (defined = amplitude scaler in stage 3).
// The quarter-wave cosine table is computed at elaboration. QTAB_FILE is kept so that
// existing instantiations still elaborate.
module dds_wave_gen #(
  parameter int PHASE_W   = 24,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 10,
  parameter     QTAB_FILE = "cos_qtab.hex"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [PHASE_W-1:0] fcw_in,
  input  logic [1:0]        sel_in,
  input  logic              phase_sync,
  input  logic [8:0]        amp,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout
);

  localparam int QN      = 1 << (ADDR_W - 2);
  localparam int MID_INT = 1 << (DATA_W - 1);
  localparam int MAX_INT = (1 << DATA_W) - 1;
  localparam logic [DATA_W-1:0] MID      = DATA_W'(MID_INT);
  localparam logic [DATA_W-1:0] ALL_ONES = '1;
  localparam logic [ADDR_W-2:0] QN_IDX   = (ADDR_W-1)'(QN);
  localparam int unused_qtab_name_bits   = $bits(QTAB_FILE);

  // Quarter-wave table Q[k] = round(MID * cos(pi/2 * k/N)), k = 0..N, using a
  // Q30 fixed-point Taylor series so no real arithmetic reaches synthesis.
  function automatic logic [(QN+1)*DATA_W-1:0] build_qtab();
    logic [(QN+1)*DATA_W-1:0] tab;
    longint x, x2, term, acc, q;
    tab = '0;
    for (int k = 0; k <= QN; k++) begin
      x    = (64'sd1686629713 * longint'(k)) / longint'(QN);
      x2   = (x * x) >>> 30;
      term = 64'sd1 <<< 30;
      acc  = term;
      for (int n = 1; n <= 6; n++) begin
        term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
        acc  = acc + term;
      end
      q = (acc * longint'(MID_INT) + (64'sd1 <<< 29)) >>> 30;
      if (q < 0) q = 0;
      if (q > longint'(MAX_INT)) q = longint'(MAX_INT);
      tab[k*DATA_W +: DATA_W] = q[DATA_W-1:0];
    end
    return tab;
  endfunction

  localparam logic [(QN+1)*DATA_W-1:0] QTAB = build_qtab();

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] fcw_act_q, fcw_act_d;
  logic [1:0]         sel_act_q, sel_act_d;
  logic [PHASE_W-1:0] fcw_sh_q, fcw_sh_d;
  logic [1:0]         sel_sh_q, sel_sh_d;
  logic               pending_q, pending_d;

  logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;
  logic [1:0]         s1_sel_q, s1_sel_d;
  logic               s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]  s2_wave_q, s2_wave_d;
  logic               s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;

`ifdef DDS_AMP_SCALE_EN
  logic [8:0]         s1_amp_q, s1_amp_d;
  logic [8:0]         s2_amp_q, s2_amp_d;
`else
  logic [8:0]         unused_amp;
  assign unused_amp = amp;
`endif

  logic [PHASE_W:0]   phase_sum;
  logic               apply_cfg;

  // Phase accumulation plus shadow/active configuration; an apply never touches the phase.
  always_comb begin
    phase_sum = {1'b0, phase_q} + {1'b0, fcw_act_q};
    apply_cfg = pending_q && (!en || phase_sum[PHASE_W]);
    phase_d   = phase_q;
    if (phase_sync) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = phase_sum[PHASE_W-1:0];
    end
    fcw_act_d = fcw_act_q;
    sel_act_d = sel_act_q;
    fcw_sh_d  = fcw_sh_q;
    sel_sh_d  = sel_sh_q;
    pending_d = pending_q;
    if (apply_cfg) begin
      fcw_act_d = fcw_sh_q;
      sel_act_d = sel_sh_q;
    end
    if (cfg_load) begin
      fcw_sh_d  = fcw_in;
      sel_sh_d  = sel_in;
      pending_d = 1'b1;
    end else if (apply_cfg) begin
      pending_d = 1'b0;
    end
  end

  // Stage 1 captures the pre-add address, active waveform, clamped amplitude and enable.
  always_comb begin
    s1_addr_d  = phase_q[PHASE_W-1 -: ADDR_W];
    s1_sel_d   = sel_act_q;
    s1_valid_d = en;
`ifdef DDS_AMP_SCALE_EN
    s1_amp_d   = (amp > 9'd256) ? 9'd256 : amp;
`endif
  end

  logic [1:0]               quad;
  logic [ADDR_W-3:0]        qk;
  logic [ADDR_W-2:0]        q_idx;
  logic [DATA_W-1:0]        q_val;
  logic signed [DATA_W+1:0] cos_sum;
  logic [DATA_W-1:0]        cos_val;
  logic [ADDR_W+DATA_W-2:0] tri_ext;
  logic [DATA_W-1:0]        tri_t;
  logic [ADDR_W+DATA_W-1:0] saw_ext;

  // Stage 2 waveform lookup: quadrant-folded cosine, square, triangle and sawtooth.
  always_comb begin
    quad  = s1_addr_q[ADDR_W-1 -: 2];
    qk    = s1_addr_q[ADDR_W-3:0];
    q_idx = quad[0] ? (QN_IDX - {1'b0, qk}) : {1'b0, qk};
    q_val = QTAB[int'(q_idx)*DATA_W +: DATA_W];
    if (quad[1] ^ quad[0]) begin
      cos_sum = $signed({2'b00, MID}) - $signed({2'b00, q_val});
    end else begin
      cos_sum = $signed({2'b00, MID}) + $signed({2'b00, q_val});
    end
    if (cos_sum < 0) begin
      cos_val = '0;
    end else if (cos_sum > $signed({2'b00, ALL_ONES})) begin
      cos_val = ALL_ONES;
    end else begin
      cos_val = cos_sum[DATA_W-1:0];
    end
    tri_ext = {s1_addr_q[ADDR_W-2:0], {DATA_W{1'b0}}};
    tri_t   = tri_ext[ADDR_W+DATA_W-2 -: DATA_W];
    saw_ext = {s1_addr_q, {DATA_W{1'b0}}};
    case (s1_sel_q)
      2'd0:    s2_wave_d = cos_val;
      2'd1:    s2_wave_d = s1_addr_q[ADDR_W-1] ? '0 : ALL_ONES;
      2'd2:    s2_wave_d = s1_addr_q[ADDR_W-1] ? (ALL_ONES - tri_t) : tri_t;
      default: s2_wave_d = saw_ext[ADDR_W+DATA_W-1 -: DATA_W];
    endcase
    s2_valid_d = s1_valid_q;
`ifdef DDS_AMP_SCALE_EN
    s2_amp_d   = s1_amp_q;
`endif
  end

`ifdef DDS_AMP_SCALE_EN
  logic signed [DATA_W:0]    wave_s;
  logic signed [DATA_W+10:0] prod;
`endif

  // Stage 3 scales around mid-scale (floor shift) and forces zero while not valid.
  always_comb begin
    dout_valid_d = s2_valid_q;
`ifdef DDS_AMP_SCALE_EN
    wave_s = $signed({1'b0, s2_wave_q}) - $signed({1'b0, MID});
    prod   = wave_s * $signed({1'b0, s2_amp_q});
    dout_d = s2_valid_q ? DATA_W'((prod >>> 8) + $signed({11'd0, MID})) : '0;
`else
    dout_d = s2_valid_q ? s2_wave_q : '0;
`endif
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= '0;
      fcw_act_q    <= '0;
      sel_act_q    <= 2'd0;
      fcw_sh_q     <= '0;
      sel_sh_q     <= 2'd0;
      pending_q    <= 1'b0;
      s1_addr_q    <= '0;
      s1_sel_q     <= 2'd0;
      s1_valid_q   <= 1'b0;
      s2_wave_q    <= '0;
      s2_valid_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef DDS_AMP_SCALE_EN
      s1_amp_q     <= '0;
      s2_amp_q     <= '0;
`endif
    end else begin
      phase_q      <= phase_d;
      fcw_act_q    <= fcw_act_d;
      sel_act_q    <= sel_act_d;
      fcw_sh_q     <= fcw_sh_d;
      sel_sh_q     <= sel_sh_d;
      pending_q    <= pending_d;
      s1_addr_q    <= s1_addr_d;
      s1_sel_q     <= s1_sel_d;
      s1_valid_q   <= s1_valid_d;
      s2_wave_q    <= s2_wave_d;
      s2_valid_q   <= s2_valid_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef DDS_AMP_SCALE_EN
      s1_amp_q     <= s1_amp_d;
      s2_amp_q     <= s2_amp_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
